// File: rtl/decode_stage_hs_pkg.sv
// Shared pipes package for the decode stage.
// Holds the fetch->decode entry type, the decoded bundle presented to
// execute, MIPS function/opcode constants and the immediate-extension helper.
// Struct pc fields are sized for the widest supported pc (64 bits); users
// cast to their own PC_W.
package decode_stage_hs_pkg;

    localparam int ENTRY_PC_W    = 64;
    localparam int ENTRY_INSTR_W = 32;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F6_SLL = 6'h00;
    localparam logic [5:0] F6_SRL = 6'h02;
    localparam logic [5:0] F6_JR  = 6'h08;
    localparam logic [5:0] F6_ADD = 6'h20;
    localparam logic [5:0] F6_SUB = 6'h22;
    localparam logic [5:0] F6_AND = 6'h24;
    localparam logic [5:0] F6_OR  = 6'h25;
    localparam logic [5:0] F6_SLT = 6'h2A;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
        logic [5:0]               op;
        logic [5:0]               func;
        logic [4:0]               rs;
        logic [4:0]               rt;
        logic [4:0]               rd;
        logic [4:0]               shamt;
        logic [31:0]              imm_ext;
        logic [ENTRY_PC_W-1:0]    branch_target;
        logic [ENTRY_PC_W-1:0]    jump_target;
        logic                     is_branch;
        logic                     is_jump;
    } decoded_t;

    // Logical immediates are zero-extended, LUI places imm in the upper half,
    // everything else (arithmetic, loads/stores, branches) sign-extends.
    function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] ext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0000, imm};
            OP_LUI:                   ext = {imm, 16'h0000};
            default:                  ext = {{16{imm[15]}}, imm};
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/decode_stage_hs_decode_fields.sv
// decode_fields: purely combinational MIPS field decoder.
// Ports:
//   entry : fetch_entry_t  {pc, instr} of the entry to decode
//   dec   : decoded_t      all decoded fields, targets computed on PC_W bits
// PC_W must lie in 29..64 (jump target keeps pc4[PC_W-1:28]).
module decode_fields
    import decode_stage_hs_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int BRANCH_SHIFT = 2
) (
    input  fetch_entry_t entry,
    output decoded_t     dec
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] br_off;
    logic [15:0]     imm;
    logic [5:0]      op;

    assign pc     = PC_W'(entry.pc);
    assign imm    = entry.instr[15:0];
    assign op     = entry.instr[31:26];
    assign pc4    = pc + PC_W'(4);
    // Sign-extend to full pc width before shifting so negative offsets wrap.
    assign br_off = {{(PC_W-16){imm[15]}}, imm} << BRANCH_SHIFT;

    always_comb begin
        dec               = '0;
        dec.pc            = entry.pc;
        dec.instr         = entry.instr;
        dec.op            = op;
        dec.func          = entry.instr[5:0];
        dec.rs            = entry.instr[25:21];
        dec.rt            = entry.instr[20:16];
        dec.rd            = entry.instr[15:11];
        dec.shamt         = entry.instr[10:6];
        dec.imm_ext       = extend_imm(op, imm);
        dec.branch_target = ENTRY_PC_W'(pc4 + br_off);
        dec.jump_target   = ENTRY_PC_W'({pc4[PC_W-1:28], entry.instr[25:0], 2'b00});
        dec.is_branch     = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
                            (op == OP_BGTZ) || (op == OP_REGIMM);
        dec.is_jump       = (op == OP_J) || (op == OP_JAL);
    end

endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: MIPS decode stage with valid/ready handshakes on both
// sides and a two-entry skid buffer (main = head, skid = overflow).
// Ports:
//   clk, resetn (sync, active-low), flush (drop all held entries)
//   in_valid/in_ready/in_pc/in_instr      : fetch side; in_ready is a flop
//   out_valid/out_ready                   : execute side handshake
//   out_pc/out_instr/out_op/out_func/out_rs/out_rt/out_rd/out_shamt
//   out_imm_ext/out_branch_target/out_jump_target/out_is_branch/out_is_jump
// Decoded outputs come combinationally from the main register only, so they
// always describe the head entry (and stay deterministic while empty).
module decode_stage_hs
    import decode_stage_hs_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              INSTR_W      = 32,
    parameter int              REG_ADDR_W   = 5,
    parameter int              BRANCH_SHIFT = 2,
    parameter logic [PC_W-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [5:0]            out_op,
    output logic [5:0]            out_func,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [4:0]            out_shamt,
    output logic [31:0]           out_imm_ext,
    output logic [PC_W-1:0]       out_branch_target,
    output logic [PC_W-1:0]       out_jump_target,
    output logic                  out_is_branch,
    output logic                  out_is_jump
);

    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q,   in_ready_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic fire_in;
    logic fire_out;

    assign fire_in  = in_valid & in_ready_q;
    assign fire_out = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Data registers keep their contents so outputs stay deterministic.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (fire_out) begin
            if (skid_valid_q) begin
                // in_ready was low, so no new entry can arrive this cycle.
                main_valid_d = 1'b1;
                main_pc_d    = skid_pc_q;
                main_instr_d = skid_instr_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = fire_in;
                if (fire_in) begin
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                end
            end
        end else if (fire_in) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end

        // Registered ready: accept whenever the skid slot will be free.
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_pc_q    <= RESET_PC;
            main_instr_q <= '0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    fetch_entry_t head;
    decoded_t     dec;

    assign head.pc    = ENTRY_PC_W'(main_pc_q);
    assign head.instr = ENTRY_INSTR_W'(main_instr_q);

    decode_fields #(
        .PC_W         (PC_W),
        .BRANCH_SHIFT (BRANCH_SHIFT)
    ) u_decode_fields (
        .entry (head),
        .dec   (dec)
    );

    assign in_ready          = in_ready_q;
    assign out_valid         = main_valid_q;
    assign out_pc            = PC_W'(dec.pc);
    assign out_instr         = INSTR_W'(dec.instr);
    assign out_op            = dec.op;
    assign out_func          = dec.func;
    assign out_rs            = REG_ADDR_W'(dec.rs);
    assign out_rt            = REG_ADDR_W'(dec.rt);
    assign out_rd            = REG_ADDR_W'(dec.rd);
    assign out_shamt         = dec.shamt;
    assign out_imm_ext       = dec.imm_ext;
    assign out_branch_target = PC_W'(dec.branch_target);
    assign out_jump_target   = PC_W'(dec.jump_target);
    assign out_is_branch     = dec.is_branch;
    assign out_is_jump       = dec.is_jump;

endmodule

// File: tb/tb_decode_stage_hs.sv
module tb_decode_stage_hs;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        br;
        logic        j;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [5:0]  out_op;
    logic [5:0]  out_func;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [31:0] out_imm_ext;
    logic [31:0] out_branch_target;
    logic [31:0] out_jump_target;
    logic        out_is_branch;
    logic        out_is_jump;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    bit   seen_pc20 = 0;
    exp_t pend;
    exp_t sb_q[$];

    logic [5:0] op_tab [0:11] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05,
                                  6'h01, 6'h02, 6'h03, 6'h08, 6'h00, 6'h23};

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_instr          (in_instr),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_instr         (out_instr),
        .out_op            (out_op),
        .out_func          (out_func),
        .out_rs            (out_rs),
        .out_rt            (out_rt),
        .out_rd            (out_rd),
        .out_shamt         (out_shamt),
        .out_imm_ext       (out_imm_ext),
        .out_branch_target (out_branch_target),
        .out_jump_target   (out_jump_target),
        .out_is_branch     (out_is_branch),
        .out_is_jump       (out_is_jump)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode written from the MIPS field definitions.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t        e;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] sx;
        logic [31:0] pc4;
        op  = ins[31:26];
        imm = ins[15:0];
        sx  = {{16{imm[15]}}, imm};
        pc4 = pc + 32'd4;
        e.pc    = pc;
        e.instr = ins;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0, imm};
        else if (op == 6'h0F)                          e.imm = {imm, 16'h0};
        else                                           e.imm = sx;
        e.bt = pc4 + (sx << 2);
        e.jt = {pc4[31:28], ins[25:0], 2'b00};
        e.br = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
        e.j  = (op == 6'h02) || (op == 6'h03);
        return e;
    endfunction

    // Offer one entry until accepted (bounded); returns just after the accepting edge.
    task automatic send(input exp_t e);
        bit ok;
        ok       = 0;
        pend     = e;
        in_pc    = e.pc;
        in_instr = e.instr;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    // Scoreboard: push on accepted input, pop/compare on output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    $display("out pc=%h instr=%h imm=%h bt=%h jt=%h br=%0d j=%0d",
                             out_pc, out_instr, out_imm_ext, out_branch_target,
                             out_jump_target, out_is_branch, out_is_jump);
                    n_out++;
                    if (out_pc == 32'h20) seen_pc20 = 1;
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_pc", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_pc",     out_pc,            e.pc);
                        check("out_instr",  out_instr,         e.instr);
                        check("imm_ext",    out_imm_ext,       e.imm);
                        check("br_target",  out_branch_target, e.bt);
                        check("jmp_target", out_jump_target,   e.jt);
                        check("is_branch",  out_is_branch,     e.br);
                        check("is_jump",    out_is_jump,       e.j);
                        check("rs",         out_rs,            e.instr[25:21]);
                        check("rt",         out_rt,            e.instr[20:16]);
                        check("op",         out_op,            e.instr[31:26]);
                    end
                end
                if (flush) sb_q.delete();
                else if (in_valid && in_ready) sb_q.push_back(pend);
            end
        end
    end

    initial begin
        exp_t e;
        int   base;

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; pend = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_pc",    out_pc,    32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Immediates, branch, jump (expected constants from the test plan)
        out_ready = 1'b1;
        e = model(32'h0040_0000, 32'h3421_8000); e.imm = 32'h0000_8000; send(e);
        e = model(32'h0040_0000, 32'h2021_8000); e.imm = 32'hFFFF_8000; send(e);
        e = model(32'h0040_0000, 32'h3C01_1234); e.imm = 32'h1234_0000; send(e);
        e = model(32'h0040_0010, 32'h1022_FFFF); e.bt = 32'h0040_0010; e.br = 1'b1; send(e);
        e = model(32'hFFFF_FFF0, 32'h1022_7FFF); e.bt = 32'h0001_FFF0; e.br = 1'b1; send(e);
        e = model(32'h8FFF_FFFC, 32'h0810_0004); e.jt = 32'h9040_0010; e.j = 1'b1; send(e);
        repeat (3) @(negedge clk);
        check("dir_out_count", n_out, 6);

        // Backpressure: two accepts fill main+skid, third stalls
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = n_out;
        send(model(32'h0, 32'h2000_0001));
        send(model(32'h4, 32'h2000_0002));
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        fork
            send(model(32'h8, 32'h2000_0003));
            begin
                repeat (3) @(negedge clk);
                check("bp_still_stalled", in_ready, 1'b0);
                check("bp_no_output", n_out - base, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("bp_out_count", n_out - base, 3);

        // Flush with both entries full, concurrent offer of pc 0x20
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(model(32'h10, 32'h2000_0010));
        send(model(32'h14, 32'h2000_0014));
        pend = model(32'h20, 32'h2000_0020);
        in_pc = 32'h20; in_instr = 32'h2000_0020; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready",  in_ready,  1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-stream with a concurrent accepted offer
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(model(32'h40, 32'h2000_0040));
        pend = model(32'h44, 32'h2000_0044);
        in_pc = 32'h44; in_instr = 32'h2000_0044; in_valid = 1'b1; resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_in_ready",  in_ready,  1'b1);
        check("mrst_out_pc",    out_pc,    32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = n_out;
        repeat (5) @(negedge clk);
        check("mrst_no_output", n_out - base, 0);

        // Random traffic with random backpressure
        base = n_out;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] ins;
                    ins = $urandom;
                    ins[31:26] = op_tab[$urandom_range(0, 11)];
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(model({$urandom} & 32'hFFFF_FFFC, ins));
                end
            end
            begin
                for (int c = 0; c < 150; c++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rand_out_count", n_out - base, 40);

        check("drain_empty", sb_q.size(), 0);
        check("pc20_never_out", seen_pc20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
